apb4_master_bridge: RTL and testbench

Single-clock APB4 initiator that converts a valid/ready request/response transaction port into APB4 SETUP/ACCESS cycles. It is the master-side counterpart to the team's APB4 slave peripherals (RTC, timers). It honours slave wait states (pready backpressure) and pslverr. A programmable wait-state timeout keeps a hung slave from stalling the requester. One outstanding transfer; the response is held until the consumer takes it.

---
 rtl/apb4_master_bridge_pkg.sv | 11 +
 rtl/apb4_master_bridge_tmo.sv | 43 ++++
 rtl/apb4_master_bridge.sv | 179 +++++++++++++++++
 tb/tb_apb4_master_bridge.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb4_master_bridge_pkg.sv
// Shared types for the APB4 master bridge: FSM state encoding.
package apb4_master_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

endpackage

// File: rtl/apb4_master_bridge_tmo.sv
// Wait-state timeout counter for the APB4 master bridge.
// Clears at SETUP, counts ACCESS cycles with pready low, and flags the
// cycle on which the transfer must be aborted (TIMEOUT=0 disables it).
module apb4_master_tmo #(
    parameter int TO_WIDTH = 8,
    parameter int TIMEOUT  = 255
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic hit_o
);

    localparam logic [TO_WIDTH-1:0] HIT_VAL =
        (TIMEOUT == 0) ? '0 : TO_WIDTH'(TIMEOUT - 1);

    logic [TO_WIDTH-1:0] cnt_q;
    logic [TO_WIDTH-1:0] cnt_d;

    // Next count: clear wins over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + TO_WIDTH'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Abort on the wait cycle that would reach TIMEOUT stalled cycles.
    assign hit_o = (TIMEOUT != 0) && inc_i && (cnt_q == HIT_VAL);

endmodule

// File: rtl/apb4_master_bridge.sv
// APB4 initiator: turns a valid/ready request into SETUP/ACCESS cycles and
// returns a held response (read data, slave error, timeout flag).
module apb4_master_bridge
    import apb4_master_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TO_WIDTH   = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [ADDR_WIDTH-1:0]   req_addr_i,
    input  logic                    req_write_i,
    input  logic [DATA_WIDTH-1:0]   req_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] req_wstrb_i,
    input  logic [2:0]              req_prot_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic                    rsp_err_o,
    output logic                    rsp_tmo_o,
    output logic [ADDR_WIDTH-1:0]   paddr_o,
    output logic [2:0]              pprot_o,
    output logic                    psel_o,
    output logic                    penable_o,
    output logic                    pwrite_o,
    output logic [DATA_WIDTH-1:0]   pwdata_o,
    output logic [DATA_WIDTH/8-1:0] pstrb_o,
    input  logic                    pready_i,
    input  logic [DATA_WIDTH-1:0]   prdata_i,
    input  logic                    pslverr_i
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    state_e                  state_q,     state_d;
    logic                    psel_q,      psel_d;
    logic                    penable_q,   penable_d;
    logic                    pwrite_q,    pwrite_d;
    logic [ADDR_WIDTH-1:0]   paddr_q,     paddr_d;
    logic [2:0]              pprot_q,     pprot_d;
    logic [DATA_WIDTH-1:0]   pwdata_q,    pwdata_d;
    logic [STRB_WIDTH-1:0]   pstrb_q,     pstrb_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    rsp_err_q,   rsp_err_d;
    logic                    rsp_tmo_q,   rsp_tmo_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;

    logic tmo_clr;
    logic tmo_inc;
    logic tmo_hit;

    assign tmo_clr = (state_q == ST_SETUP);
    assign tmo_inc = (state_q == ST_ACCESS) && !pready_i;

    apb4_master_tmo #(
        .TO_WIDTH (TO_WIDTH),
        .TIMEOUT  (TIMEOUT)
    ) u_tmo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clr_i   (tmo_clr),
        .inc_i   (tmo_inc),
        .hit_o   (tmo_hit)
    );

    // Next-state and next-output logic for the transfer FSM.
    always_comb begin
        // NOTE: every _d starts from its _q so no path leaves a signal unassigned (no latches).
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pprot_d     = pprot_q;
        pwdata_d    = pwdata_q;
        pstrb_d     = pstrb_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_tmo_d   = rsp_tmo_q;
        rsp_rdata_d = rsp_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    state_d   = ST_SETUP;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    paddr_d   = req_addr_i;
                    pwrite_d  = req_write_i;
                    pprot_d   = req_prot_i;
                    pwdata_d  = req_write_i ? req_wdata_i : '0;
                    pstrb_d   = req_write_i ? req_wstrb_i : '0;
                end
            end
            ST_SETUP: begin
                state_d   = ST_ACCESS;
                penable_d = 1'b1;
            end
            ST_ACCESS: begin
                if (pready_i) begin
                    state_d     = ST_RESP;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = pslverr_i;
                    rsp_tmo_d   = 1'b0;
                    rsp_rdata_d = (!pwrite_q && !pslverr_i) ? prdata_i : '0;
                end else if (tmo_hit) begin
                    state_d     = ST_RESP;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_tmo_d   = 1'b1;
                    rsp_rdata_d = '0;
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered APB/response outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pprot_q     <= '0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_tmo_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pprot_q     <= pprot_d;
            pwdata_q    <= pwdata_d;
            pstrb_q     <= pstrb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_tmo_q   <= rsp_tmo_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign req_ready_o = (state_q == ST_IDLE);
    assign psel_o      = psel_q;
    assign penable_o   = penable_q;
    assign pwrite_o    = pwrite_q;
    assign paddr_o     = paddr_q;
    assign pprot_o     = pprot_q;
    assign pwdata_o    = pwdata_q;
    assign pstrb_o     = pstrb_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_tmo_o   = rsp_tmo_q;
    assign rsp_rdata_o = rsp_rdata_q;

endmodule

// File: tb/tb_apb4_master_bridge.sv
// Self-checking bench for apb4_master_bridge (TIMEOUT=4): directed APB
// transfers with a response scoreboard filled at issue time.
`timescale 1ns/1ps
module tb_apb4_master_bridge;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          clk_i = 1'b0;
    logic          rst_n_i;
    logic          req_valid_i;
    logic          req_ready_o;
    logic [AW-1:0] req_addr_i;
    logic          req_write_i;
    logic [DW-1:0] req_wdata_i;
    logic [SW-1:0] req_wstrb_i;
    logic [2:0]    req_prot_i;
    logic          rsp_valid_o;
    logic          rsp_ready_i;
    logic [DW-1:0] rsp_rdata_o;
    logic          rsp_err_o;
    logic          rsp_tmo_o;
    logic [AW-1:0] paddr_o;
    logic [2:0]    pprot_o;
    logic          psel_o;
    logic          penable_o;
    logic          pwrite_o;
    logic [DW-1:0] pwdata_o;
    logic [SW-1:0] pstrb_o;
    logic          pready_i;
    logic [DW-1:0] prdata_i;
    logic          pslverr_i;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        logic          tmo;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk_i = ~clk_i;

    apb4_master_bridge #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .TO_WIDTH   (8),
        .TIMEOUT    (4)
    ) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_addr_i  (req_addr_i),
        .req_write_i (req_write_i),
        .req_wdata_i (req_wdata_i),
        .req_wstrb_i (req_wstrb_i),
        .req_prot_i  (req_prot_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o   (rsp_err_o),
        .rsp_tmo_o   (rsp_tmo_o),
        .paddr_o     (paddr_o),
        .pprot_o     (pprot_o),
        .psel_o      (psel_o),
        .penable_o   (penable_o),
        .pwrite_o    (pwrite_o),
        .pwdata_o    (pwdata_o),
        .pstrb_o     (pstrb_o),
        .pready_i    (pready_i),
        .prdata_i    (prdata_i),
        .pslverr_i   (pslverr_i)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_exp(input logic [DW-1:0] rdata, input logic err, input logic tmo);
        exp_t e;
        e.rdata = rdata;
        e.err   = err;
        e.tmo   = tmo;
        sb_q.push_back(e);
    endtask

    // Present a request, take it on the next edge, and check the SETUP phase.
    task automatic issue(input logic [AW-1:0] addr, input logic wr, input logic [DW-1:0] wdata,
                         input logic [SW-1:0] strb, input logic [2:0] prot);
        req_addr_i  = addr;
        req_write_i = wr;
        req_wdata_i = wdata;
        req_wstrb_i = strb;
        req_prot_i  = prot;
        req_valid_i = 1'b1;
        check("issue_req_ready", req_ready_o, 1);
        step();
        req_valid_i = 1'b0;
        check("setup_psel", psel_o, 1);
        check("setup_penable", penable_o, 0);
        check("setup_paddr", paddr_o, addr);
        check("setup_pwrite", pwrite_o, wr);
        check("setup_pprot", pprot_o, prot);
        check("setup_pwdata", pwdata_o, wr ? wdata : '0);
        check("setup_pstrb", pstrb_o, wr ? strb : '0);
    endtask

    // Response monitor: the handshake completes on the edge after this negedge.
    always @(negedge clk_i) begin
        if (rst_n_i && rsp_valid_o && rsp_ready_i) begin
            if (sb_q.size() == 0) begin
                check("rsp_unexpected", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("rsp_rdata", rsp_rdata_o, e.rdata);
                check("rsp_err", rsp_err_o, e.err);
                check("rsp_tmo", rsp_tmo_o, e.tmo);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_acc;

        rst_n_i     = 1'b0;
        req_valid_i = 1'b0;
        req_addr_i  = '0;
        req_write_i = 1'b0;
        req_wdata_i = '0;
        req_wstrb_i = '0;
        req_prot_i  = '0;
        rsp_ready_i = 1'b1;
        pready_i    = 1'b0;
        prdata_i    = '0;
        pslverr_i   = 1'b0;

        // Reset state.
        #1;
        check("rst_req_ready", req_ready_o, 1);
        check("rst_psel", psel_o, 0);
        check("rst_penable", penable_o, 0);
        check("rst_paddr", paddr_o, 0);
        check("rst_pwdata", pwdata_o, 0);
        check("rst_rsp_valid", rsp_valid_o, 0);
        check("rst_rsp_rdata", rsp_rdata_o, 0);
        repeat (3) step();
        rst_n_i = 1'b1;
        step();

        // Zero-wait write.
        pready_i = 1'b1;
        issue(32'h0000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'd0);
        push_exp('0, 1'b0, 1'b0);
        step();
        check("w0_access_psel", psel_o, 1);
        check("w0_access_penable", penable_o, 1);
        step();
        check("w0_rsp_valid", rsp_valid_o, 1);
        check("w0_resp_psel", psel_o, 0);
        check("w0_resp_penable", penable_o, 0);
        pready_i = 1'b0;
        step();
        check("w0_idle_req_ready", req_ready_o, 1);
        check("w0_idle_rsp_valid", rsp_valid_o, 0);

        // Read with 3 wait states; completes on the 4th ACCESS cycle (also the timeout boundary).
        issue(32'h0000_0020, 1'b0, 32'hFFFF_FFFF, 4'hF, 3'd5);
        push_exp(32'h1234_5678, 1'b0, 1'b0);
        step();
        for (int k = 1; k <= 4; k++) begin
            check("r3_penable", penable_o, 1);
            check("r3_paddr_stable", paddr_o, 32'h0000_0020);
            check("r3_pstrb_zero", pstrb_o, 0);
            check("r3_rsp_valid_low", rsp_valid_o, 0);
            if (k == 4) begin
                pready_i = 1'b1;
                prdata_i = 32'h1234_5678;
            end
            step();
        end
        check("r3_rsp_valid", rsp_valid_o, 1);
        check("r3_rsp_tmo", rsp_tmo_o, 0);
        check("r3_psel_drop", psel_o, 0);
        pready_i = 1'b0;
        prdata_i = 32'h5555_AAAA;
        step();

        // Read with slave error.
        issue(32'h0000_0024, 1'b0, '0, '0, 3'd1);
        push_exp('0, 1'b1, 1'b0);
        step();
        pready_i  = 1'b1;
        pslverr_i = 1'b1;
        prdata_i  = 32'hCAFE_F00D;
        step();
        check("err_rsp_valid", rsp_valid_o, 1);
        check("err_rsp_err", rsp_err_o, 1);
        pready_i  = 1'b0;
        pslverr_i = 1'b0;
        step();

        // Timeout: pready never asserted.
        issue(32'h0000_0050, 1'b0, '0, '0, 3'd0);
        push_exp('0, 1'b1, 1'b1);
        n_acc = 0;
        for (int i = 0; i < 20 && psel_o; i++) begin
            step();
            if (penable_o) n_acc++;
        end
        check("tmo_psel_dropped", psel_o, 0);
        check("tmo_access_cycles", n_acc, 4);
        check("tmo_rsp_valid", rsp_valid_o, 1);
        check("tmo_rsp_tmo", rsp_tmo_o, 1);
        step();

        // Response backpressure with a pending request.
        rsp_ready_i = 1'b0;
        pready_i    = 1'b1;
        prdata_i    = 32'hA5A5_5A5A;
        issue(32'h0000_0030, 1'b0, '0, '0, 3'd0);
        push_exp(32'hA5A5_5A5A, 1'b0, 1'b0);
        step();
        step();
        pready_i    = 1'b0;
        req_addr_i  = 32'h0000_0040;
        req_write_i = 1'b1;
        req_wdata_i = 32'h1122_3344;
        req_wstrb_i = 4'h3;
        req_prot_i  = 3'd2;
        req_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("stall_rsp_valid", rsp_valid_o, 1);
            check("stall_rsp_rdata", rsp_rdata_o, 32'hA5A5_5A5A);
            check("stall_rsp_err", rsp_err_o, 0);
            check("stall_req_ready", req_ready_o, 0);
            check("stall_psel", psel_o, 0);
            prdata_i = $urandom;
            step();
        end
        rsp_ready_i = 1'b1;
        step();
        check("stall_done_req_ready", req_ready_o, 1);
        check("stall_done_rsp_valid", rsp_valid_o, 0);
        step();
        req_valid_i = 1'b0;
        check("next_psel", psel_o, 1);
        check("next_paddr", paddr_o, 32'h0000_0040);
        check("next_pwdata", pwdata_o, 32'h1122_3344);
        check("next_pstrb", pstrb_o, 4'h3);
        push_exp('0, 1'b0, 1'b0);
        pready_i = 1'b1;
        step();
        step();
        check("next_rsp_valid", rsp_valid_o, 1);
        pready_i = 1'b0;
        step();

        // Reset in the middle of ACCESS.
        issue(32'h0000_0060, 1'b1, 32'h0F0F_0F0F, 4'hF, 3'd0);
        step();
        check("rstmid_penable_before", penable_o, 1);
        #2;
        rst_n_i = 1'b0;
        #1;
        check("rstmid_psel", psel_o, 0);
        check("rstmid_penable", penable_o, 0);
        check("rstmid_paddr", paddr_o, 0);
        check("rstmid_req_ready", req_ready_o, 1);
        step();
        rst_n_i = 1'b1;
        step();
        step();
        check("rstmid_no_rsp", rsp_valid_o, 0);
        pready_i = 1'b1;
        prdata_i = 32'h0BAD_CAFE;
        issue(32'h0000_0070, 1'b0, '0, '0, 3'd0);
        push_exp(32'h0BAD_CAFE, 1'b0, 1'b0);
        step();
        step();
        check("rstmid_fresh_rsp_valid", rsp_valid_o, 1);
        pready_i = 1'b0;
        step();
        step();

        check("sb_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
